// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: next-PC mode encoding.
package pc_pkg;
  localparam int PC_MODE_W = 3;

  typedef enum logic [PC_MODE_W-1:0] {
    MODE_SEQ    = 3'd0,
    MODE_BRANCH = 3'd1,
    MODE_JUMP   = 3'd2,
    MODE_CALL   = 3'd3,
    MODE_RET    = 3'd4,
    MODE_HOLD   = 3'd5
  } pc_mode_t;
endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is refused and flagged. Top-of-stack is read combinationally.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4,
  localparam int CW = $clog2(RAS_DEPTH + 1),
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top_data,
  output logic [CW-1:0]   count,
  output logic            ovf,
  output logic            unf
);
  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   top_idx;
  logic [PW-1:0]   ptr_inc;
  logic            full;
  logic            empty;

  // ptr is the next write slot; the top entry sits one slot below it.
  assign top_idx  = (ptr == '0) ? PW'(RAS_DEPTH - 1) : ptr - 1'b1;
  assign ptr_inc  = (ptr == PW'(RAS_DEPTH - 1)) ? '0 : ptr + 1'b1;
  assign full     = (count == CW'(RAS_DEPTH));
  assign empty    = (count == '0);
  assign top_data = mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ovf <= push && full;
      unf <= pop && empty;
      if (push) begin
        ptr <= ptr_inc;
        if (!full) count <= count + 1'b1;
      end else if (pop && !empty) begin
        ptr   <= top_idx;
        count <= count - 1'b1;
      end
    end
  end

  // Storage carries no reset: contents are don't-care once the count is cleared.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter with stall, branch/jump/call/return modes and an internal
// return-address stack. out_pc is registered and feeds instruction memory.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int          INC       = 4,
  parameter int          RAS_DEPTH = 4,
  localparam int CW = $clog2(RAS_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [PC_MODE_W-1:0] mode,
  input  logic                 cond,
  input  logic [XLEN-1:0]      in_pc,
  output logic [XLEN-1:0]      out_pc,
  output logic                 zero,
  output logic [CW-1:0]        ras_count,
  output logic                 ras_ovf,
  output logic                 ras_unf
);
  logic [XLEN-1:0] seq;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] ras_top;
  logic            push;
  logic            pop;

  assign seq  = out_pc + XLEN'(INC);
  assign push = en && (mode == MODE_CALL);
  assign pop  = en && (mode == MODE_RET);
  assign zero = (out_pc == '0);

  always_comb begin
    pc_next = seq;
    case (mode)
      MODE_BRANCH: pc_next = cond ? in_pc : seq;
      MODE_JUMP:   pc_next = in_pc;
      MODE_CALL:   pc_next = in_pc;
      MODE_RET:    pc_next = (ras_count != '0) ? ras_top : seq;
      MODE_HOLD:   pc_next = out_pc;
      default:     pc_next = seq;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_pc <= RESET_VEC;
    else if (en) out_pc <= pc_next;
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (seq),
    .top_data  (ras_top),
    .count     (ras_count),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );
endmodule
